// File: rtl/car_motion_if.sv
// Signal bundle between the elevator state controller and the car travel model.
interface car_motion_if;
  logic       dir;
  logic       door;
  logic [2:0] floor;
  logic       arrive;
  logic       moving;
  logic       at_limit;

  modport master (output dir, output door,
                  input floor, input arrive, input moving, input at_limit);
  modport slave  (input dir, input door,
                  output floor, output arrive, output moving, output at_limit);
endinterface

// File: rtl/car_motion.sv
// Car travel model: per-floor travel timer, post-arrival settle hold, and
// limit protection so the floor index never leaves 0..TOP_FLOOR.
module car_motion #(
  parameter int unsigned TRAVEL_CYCLES = 100,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TOP_FLOOR     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  car_motion_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MOVING, SETTLE} state_t;

  localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_CYCLES - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0]  TOP         = 3'(TOP_FLOOR);

  state_t      state_q, state_d;
  logic [2:0]  floor_q, floor_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  settle_q, settle_d;
  logic        ldir_q, ldir_d;
  logic        arrive_q, arrive_d;
  logic        moving_q, moving_d;
  logic        at_limit;

  always_comb begin
    at_limit = (bus.dir && (floor_q == TOP)) || (!bus.dir && (floor_q == '0));
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    ldir_d   = ldir_q;
    arrive_d = 1'b0;
    moving_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.door && !at_limit) begin
          state_d = MOVING;
          timer_d = '0;
          ldir_d  = bus.dir;
        end
      end
      MOVING: begin
        if (bus.door) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (bus.dir != ldir_q) begin
          // Reversal discards partial travel; reversing into a limit stops the car.
          timer_d = '0;
          if (at_limit) state_d = IDLE;
          else          ldir_d  = bus.dir;
        end else if (timer_q == TRAVEL_LAST) begin
          floor_d  = ldir_q ? floor_q + 3'd1 : floor_q - 3'd1;
          arrive_d = 1'b1;
          state_d  = SETTLE;
          settle_d = '0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = IDLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d == MOVING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      timer_q  <= '0;
      settle_q <= '0;
      ldir_q   <= 1'b0;
      arrive_q <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      ldir_q   <= ldir_d;
      arrive_q <= arrive_d;
      moving_q <= moving_d;
    end
  end

  assign bus.floor    = floor_q;
  assign bus.arrive   = arrive_q;
  assign bus.moving   = moving_q;
  assign bus.at_limit = at_limit;

endmodule
